// File: rtl/mux_indexed_fifo.sv
`default_nettype none
// ============================================================================
// Module   : mux_indexed_fifo
// Brief    : Index-steered data mux feeding a SLOTS-deep output FIFO.
// Revision : 1.0  initial release
// ============================================================================
module mux_indexed_fifo #(
    parameter int SIZE       = 2,
    parameter int DATA_TYPE  = 32,
    parameter int INDEX_TYPE = 1,
    parameter int SLOTS      = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [SIZE*DATA_TYPE-1:0] ins,
    input  logic [SIZE-1:0]           ins_valid,
    output logic [SIZE-1:0]           ins_ready,
    input  logic [INDEX_TYPE-1:0]     index,
    input  logic                      index_valid,
    output logic                      index_ready,
    output logic [DATA_TYPE-1:0]      outs,
    output logic                      outs_valid,
    input  logic                      outs_ready
);

    localparam int c_PTR_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int c_CNT_W = $clog2(SLOTS + 1);
    localparam logic [c_PTR_W-1:0]  c_LAST = c_PTR_W'(SLOTS - 1);
    localparam logic [c_CNT_W-1:0]  c_FULL = c_CNT_W'(SLOTS);
    localparam logic [INDEX_TYPE:0] c_SIZE = (INDEX_TYPE + 1)'(SIZE);

    logic [DATA_TYPE-1:0] r_mem [SLOTS];
    logic [c_PTR_W-1:0]   r_head;
    logic [c_PTR_W-1:0]   r_tail;
    logic [c_CNT_W-1:0]   r_count;

    logic                 w_legal;
    logic                 w_sel_valid;
    logic [DATA_TYPE-1:0] w_sel_data;
    logic                 w_space;
    logic                 w_fire;
    logic                 w_pop;

    // Loop-based select keeps an out-of-range index from reading past the bus.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_data  = '0;
        for (int i = 0; i < SIZE; i++) begin
            if (index == INDEX_TYPE'(i)) begin
                w_sel_valid = ins_valid[i];
                w_sel_data  = ins[i*DATA_TYPE +: DATA_TYPE];
            end
        end
    end

    assign w_legal     = {1'b0, index} < c_SIZE;
    assign outs_valid  = (r_count != '0);
    assign outs        = r_mem[r_head];
    assign w_pop       = outs_valid & outs_ready;
    // A pop in the same cycle frees a slot, so a full FIFO still streams.
    assign w_space     = (r_count < c_FULL) | w_pop;
    assign w_fire      = index_valid & w_legal & w_sel_valid & w_space & ~rst;
    assign index_ready = w_fire;

    generate
        for (genvar g = 0; g < SIZE; g++) begin : g_ins_ready
            assign ins_ready[g] = w_fire & (index == INDEX_TYPE'(g));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (w_fire) begin
            r_mem[r_tail] <= w_sel_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_fire) begin
                r_tail <= (r_tail == c_LAST) ? '0 : r_tail + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_head <= (r_head == c_LAST) ? '0 : r_head + c_PTR_W'(1);
            end
            case ({w_fire, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire
